if_id_pipe_reg: RTL and testbench

Holds the architectural PC register and the IF/ID pipeline latch of the 5-stage pipeline. It sits between `instruction_fetch` and decode. It takes `npc`, `pc4` and `inst` from fetch, feeds `pc` back to fetch, and presents a registered `pc4`/`inst` pair with a valid bit to ID. It also applies the hazard unit's stall and the branch/exception flush, and keeps saturating stall/flush event counters and a sticky misaligned-PC flag.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/sat_counter.sv | 20 ++
 rtl/if_id_pipe_reg.sv | 73 +++++++
 tb/tb_if_id_pipe_reg.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline types, defaults and PC-source encodings
package cpu_pkg;

  typedef logic [31:0] word_t;

  // Default reset PC and the bubble encoding (sll $0,$0,0)
  localparam word_t DEF_RESET_PC = 32'h0000_0000;
  localparam word_t DEF_NOP_INST = 32'h0000_0000;

  // Next-PC source select shared by fetch and the hazard unit
  typedef enum logic [1:0] {
    PCSRC_PC4    = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_ZERO   = 2'b11
  } pcsrc_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter, cleared only by reset
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count events, sticking at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/if_id_pipe_reg.sv
// rtl/if_id_pipe_reg.sv - PC register and IF/ID latch with stall, flush and event counters
module if_id_pipe_reg
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC = DEF_RESET_PC,
  parameter word_t NOP_INST = DEF_NOP_INST,
  parameter int    CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      npc,
  input  logic [31:0]      if_pc4,
  input  logic [31:0]      if_inst,
  output logic [31:0]      pc,
  output logic [31:0]      id_pc4,
  output logic [31:0]      id_inst,
  output logic             id_valid,
  output logic             pc_misalign,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // npc is consumed whenever the PC moves: a flush redirects even under stall
  logic advance;
  logic stall_applied;

  assign advance       = flush | ~stall;
  assign stall_applied = stall & ~flush;

  // PC and IF/ID latch; priority is reset, then flush, then stall, then normal
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      id_pc4      <= '0;
      id_inst     <= NOP_INST;
      id_valid    <= 1'b0;
      pc_misalign <= 1'b0;
    end else begin
      if (advance) begin
        pc <= {npc[31:2], 2'b00};
        if (npc[1:0] != 2'b00) begin
          pc_misalign <= 1'b1;
        end
      end
      if (flush) begin
        id_pc4   <= '0;
        id_inst  <= NOP_INST;
        id_valid <= 1'b0;
      end else if (!stall) begin
        id_pc4   <= if_pc4;
        id_inst  <= if_inst;
        id_valid <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_applied),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// tb/tb_if_id_pipe_reg.sv - scoreboard bench for the IF/ID pipeline register
module tb_if_id_pipe_reg;

  localparam int          CNT_W = 4;
  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic [31:0]      npc = '0;
  logic [31:0]      if_pc4 = '0;
  logic [31:0]      if_inst = '0;
  logic [31:0]      pc;
  logic [31:0]      id_pc4;
  logic [31:0]      id_inst;
  logic             id_valid;
  logic             pc_misalign;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  if_id_pipe_reg #(
    .RESET_PC (RPC),
    .NOP_INST (NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .npc         (npc),
    .if_pc4      (if_pc4),
    .if_inst     (if_inst),
    .pc          (pc),
    .id_pc4      (id_pc4),
    .id_inst     (id_inst),
    .id_valid    (id_valid),
    .pc_misalign (pc_misalign),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      pc;
    logic [31:0]      pc4;
    logic [31:0]      inst;
    logic             valid;
    logic             mis;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  logic [31:0]      m_pc = '0;
  logic [31:0]      m_pc4 = '0;
  logic [31:0]      m_inst = '0;
  logic             m_valid = 1'b0;
  logic             m_mis = 1'b0;
  logic [CNT_W-1:0] m_sc = '0;
  logic [CNT_W-1:0] m_fc = '0;
  logic [31:0]      held_inst;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle, predict the registered result, then compare after the edge
  task automatic apply(input logic r, input logic s, input logic f,
                       input logic [31:0] n, input logic [31:0] p4, input logic [31:0] ins);
    exp_t e;
    rst = r; stall = s; flush = f; npc = n; if_pc4 = p4; if_inst = ins;
    if (r) begin
      m_pc = RPC; m_pc4 = '0; m_inst = NOP; m_valid = 1'b0; m_mis = 1'b0;
      m_sc = '0; m_fc = '0;
    end else if (f) begin
      m_pc = {n[31:2], 2'b00}; m_pc4 = '0; m_inst = NOP; m_valid = 1'b0;
      if (n[1:0] != 2'b00) m_mis = 1'b1;
      if (m_fc != '1) m_fc = m_fc + 1'b1;
    end else if (s) begin
      if (m_sc != '1) m_sc = m_sc + 1'b1;
    end else begin
      m_pc = {n[31:2], 2'b00}; m_pc4 = p4; m_inst = ins; m_valid = 1'b1;
      if (n[1:0] != 2'b00) m_mis = 1'b1;
    end
    e.pc = m_pc; e.pc4 = m_pc4; e.inst = m_inst; e.valid = m_valid;
    e.mis = m_mis; e.sc = m_sc; e.fc = m_fc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("pc",       pc,                  e.pc);
    check_eq("id_pc4",   id_pc4,              e.pc4);
    check_eq("id_inst",  id_inst,             e.inst);
    check_eq("id_valid", {31'b0, id_valid},   {31'b0, e.valid});
    check_eq("misalign", {31'b0, pc_misalign}, {31'b0, e.mis});
    check_eq("stall_cnt", {28'b0, stall_cnt}, {28'b0, e.sc});
    check_eq("flush_cnt", {28'b0, flush_cnt}, {28'b0, e.fc});
  endtask

  // Normal fetch cycle: npc is the next sequential address
  task automatic fetch(input logic [31:0] n, input logic [31:0] ins);
    apply(1'b0, 1'b0, 1'b0, n, pc + 32'd4, ins);
  endtask

  initial begin
    // Reset sequence
    apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    check_eq("rst_pc",    pc,                RPC);
    check_eq("rst_valid", {31'b0, id_valid}, 32'd0);
    check_eq("rst_inst",  id_inst,           NOP);
    apply(1'b0, 1'b0, 1'b0, 32'h4, 32'h4, 32'h2001_0005);
    check_eq("rel_pc",    pc,                32'h4);
    check_eq("rel_inst",  id_inst,           32'h2001_0005);
    check_eq("rel_pc4",   id_pc4,            32'h4);
    check_eq("rel_valid", {31'b0, id_valid}, 32'd1);

    // Advance to pc=0x10, then stall two cycles
    fetch(32'h8,  32'h2002_0008);
    fetch(32'hC,  32'h2003_000C);
    fetch(32'h10, 32'h2004_0010);
    check_eq("pre_stall_pc", pc, 32'h10);
    held_inst = id_inst;
    repeat (2) begin
      apply(1'b0, 1'b1, 1'b0, 32'h14, 32'h14, 32'hDEAD_BEEF);
      check_eq("stall_pc",   pc,      32'h10);
      check_eq("stall_inst", id_inst, held_inst);
    end
    check_eq("stall_cnt2", {28'b0, stall_cnt}, 32'd2);
    fetch(32'h14, 32'h2005_0014);
    check_eq("resume_pc", pc, 32'h14);

    // Flush beats stall
    apply(1'b0, 1'b1, 1'b1, 32'h40, 32'h18, 32'h2006_0018);
    check_eq("flush_pc",    pc,                 32'h40);
    check_eq("flush_valid", {31'b0, id_valid},  32'd0);
    check_eq("flush_inst",  id_inst,            NOP);
    check_eq("flush_cnt1",  {28'b0, flush_cnt}, 32'd1);
    check_eq("flush_sc",    {28'b0, stall_cnt}, 32'd2);

    // Back-to-back flushes
    apply(1'b0, 1'b0, 1'b1, 32'h80, 32'h44, 32'h1111_1111);
    apply(1'b0, 1'b0, 1'b1, 32'h90, 32'h84, 32'h2222_2222);
    check_eq("bb_flush_cnt", {28'b0, flush_cnt}, 32'd3);

    // Misaligned npc, then aligned PCs keep the flag
    fetch(32'h0000_0102, 32'h3333_3333);
    check_eq("mis_pc",   pc,                   32'h100);
    check_eq("mis_flag", {31'b0, pc_misalign}, 32'd1);
    fetch(32'h104, 32'h4444_4444);
    fetch(32'h108, 32'h5555_5555);
    check_eq("mis_sticky", {31'b0, pc_misalign}, 32'd1);

    // PC wrap is legal
    fetch(32'hFFFF_FFFC, 32'h6666_6666);
    fetch(32'h0, 32'h7777_7777);
    check_eq("wrap_pc", pc, 32'h0);

    // Random mix of stall/flush/normal
    for (int i = 0; i < 40; i++) begin
      apply(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
            $urandom, $urandom, $urandom);
    end

    // Saturation of stall counter
    apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (20) apply(1'b0, 1'b1, 1'b0, 32'h20, 32'h20, 32'h8888_8888);
    check_eq("sat_stall", {28'b0, stall_cnt}, 32'hF);

    // Reset mid-stall
    apply(1'b1, 1'b1, 1'b0, 32'h20, 32'h20, 32'h8888_8888);
    check_eq("rms_pc",    pc,                   RPC);
    check_eq("rms_valid", {31'b0, id_valid},    32'd0);
    check_eq("rms_sc",    {28'b0, stall_cnt},   32'd0);
    check_eq("rms_mis",   {31'b0, pc_misalign}, 32'd0);

    // Reset mid-flush
    fetch(32'h4, 32'h9999_9999);
    apply(1'b1, 1'b0, 1'b1, 32'h40, 32'h8, 32'hAAAA_AAAA);
    check_eq("rmf_fc", {28'b0, flush_cnt}, 32'd0);

    check_eq("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
